raw_stream_framer: RTL
======================

// Module: raw_stream_framer
// PURPOSE
//  Converts free-running sensor RAW beats (valid-only, no backpressure) into an AXI4-Stream
//  video frame: crops a parametrised window, marks SOF (tuser) and EOL (tlast), and absorbs
//  downstream stalls in an internal FWFT FIFO. Sits between the CSI/RAW depacketiser and the
//  VDMA/stream interconnect. Reports overflow and line/frame geometry errors.
// PARAMETERS
//  DATA_WIDTH   40    beat width (4 x RAW10)
//  TDEST_WIDTH  10    tdest width
//  TDEST_VALUE  0     constant driven on O_raw_tdest
//  H_ACTIVE     480   beats output per line
//  V_ACTIVE     1080  lines output per frame
//  H_OFFSET     0     first captured beat index in line (0-based)
//  V_OFFSET     1     first captured row index (row 0 = beats before first gap)
//  GAP_CYCLES   10    consecutive invalid cycles that terminate a line
//  FIFO_DEPTH   16    output FIFO entries, power of 2, >=4
// PORTS
//  I_clk              in   1            clock
//  I_rst_n            in   1            async active-low reset
//  I_raw_data         in   DATA_WIDTH   input beat
//  I_raw_valid        in   1            beat valid; no backpressure
//  I_raw_frame_start  in   1            1-cycle frame start pulse
//  I_raw_frame_end    in   1            1-cycle frame end pulse
//  O_raw_tdata        out  DATA_WIDTH   AXIS data
//  O_raw_tvalid       out  1            AXIS valid
//  O_raw_tready       in   1            AXIS ready
//  O_raw_tlast        out  1            last beat of line
//  O_raw_tuser        out  1            first beat of frame
//  O_raw_tdest        out  TDEST_WIDTH  = TDEST_VALUE
//  O_overflow         out  1            sticky: beat dropped, FIFO full
//  O_line_err         out  1            1-cycle pulse: captured line ended short
//  O_frame_err        out  1            1-cycle pulse: captured rows != V_ACTIVE at frame_end
// BEHAVIOUR
//  Reset: all outputs 0 except O_raw_tdest=TDEST_VALUE; FIFO empty; counters 0; state IDLE.
//  Input stage: data/valid registered 1 cycle; counters act on registered beat.
//  gap_cnt: cleared by valid; increments while invalid, saturates at GAP_CYCLES; line end =
//   cycle gap_cnt reaches GAP_CYCLES (one event per gap, never repeats while idle).
//  col: 0-based beat index, cleared at line end and frame_start. row: +1 at line end.
//  FSM: IDLE -(frame_start)-> ACTIVE -(frame_end)-> IDLE. In IDLE no beats captured.
//   frame_start in any state: col, row, gap_cnt, row_count cleared, enter ACTIVE, clear
//   O_overflow. Beat coinciding with frame_start is col 0 of row 0.
//  Capture: ACTIVE && V_OFFSET<=row<V_OFFSET+V_ACTIVE && H_OFFSET<=col<H_OFFSET+H_ACTIVE.
//   Beats outside window discarded. Beats beyond H_ACTIVE in a line discarded silently.
//  Sideband stored per entry: tuser=first captured beat of frame; tlast=col==H_OFFSET+H_ACTIVE-1.
//  Latency: empty FIFO, tready=1 -> beat on O_raw_tdata/tvalid 2 cycles after input sample.
//  AXIS: tdata/tlast/tuser stable while tvalid && !tready; pop on tvalid&&tready; tvalid low
//   when empty. Simultaneous push and pop when full: allowed, no drop.
//  Full: captured beat with FIFO full (no pop same cycle) dropped, O_overflow=1 (sticky).
//  Line end inside row window with 0<captured beats<H_ACTIVE: O_line_err pulse; no tlast
//   is fabricated; row still counts toward row_count.
//  frame_end: if row_count(lines with >=1 captured beat) != V_ACTIVE, O_frame_err pulse.
//  FIFO contents never flushed by frame_start/frame_end; drain normally. Async reset
//   mid-frame empties FIFO, drops tvalid immediately.
// TESTING
//  H_ACTIVE=4,V_ACTIVE=2,gap 10: frame_start, 3 lines x 6 beats -> 8 beats out, tuser on
//   beat0 of row1 only, tlast on col 3 of rows 1,2; no errors.
//  Same stimulus, tready=0 for 20 cycles, FIFO_DEPTH=4 -> 4 beats held stable, rest dropped,
//   O_overflow=1 until next frame_start.
//  Row 1 of only 2 beats -> O_line_err 1 pulse; frame_end with 1 complete row -> O_frame_err.
//  frame_start mid-line 1 -> counters restart; next row1 beat carries tuser; old beats drain.
//  Gap of 9 invalid cycles -> no line end; 40 idle cycles -> exactly one row increment.
//  Assert I_rst_n=0 with 3 beats queued -> tvalid=0 asynchronously, all flags 0.

Source files
------------

// File: rtl/raw_stream_framer.sv
// Crops a RAW sensor beat stream into an AXI4-Stream video window, tagging SOF/EOL, buffering
// in a small FWFT FIFO, and flagging overflow and line/frame geometry errors.
module raw_stream_framer #(
    parameter int DATA_WIDTH  = 40,
    parameter int TDEST_WIDTH = 10,
    parameter int TDEST_VALUE = 0,
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 1080,
    parameter int H_OFFSET    = 0,
    parameter int V_OFFSET    = 1,
    parameter int GAP_CYCLES  = 10,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic [DATA_WIDTH-1:0]  I_raw_data,
    input  logic                   I_raw_valid,
    input  logic                   I_raw_frame_start,
    input  logic                   I_raw_frame_end,
    output logic [DATA_WIDTH-1:0]  O_raw_tdata,
    output logic                   O_raw_tvalid,
    input  logic                   O_raw_tready,
    output logic                   O_raw_tlast,
    output logic                   O_raw_tuser,
    output logic [TDEST_WIDTH-1:0] O_raw_tdest,
    output logic                   O_overflow,
    output logic                   O_line_err,
    output logic                   O_frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [CW-1:0] H_LO     = CW'(H_OFFSET);
    localparam logic [CW-1:0] H_HI     = CW'(H_OFFSET + H_ACTIVE);
    localparam logic [CW-1:0] H_LAST   = CW'(H_OFFSET + H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LO     = CW'(V_OFFSET);
    localparam logic [CW-1:0] V_HI     = CW'(V_OFFSET + V_ACTIVE);
    localparam logic [CW-1:0] GAP_MAX  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CAP_FULL = CW'(H_ACTIVE);
    localparam logic [CW-1:0] ROWS_EXP = CW'(V_ACTIVE);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, fs_q, fe_q;
    logic [CW-1:0]         gap_q, gap_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CW-1:0]         cap_q, cap_d;
    logic [CW-1:0]         rows_q, rows_d;
    logic                  sof_q, sof_d;
    logic                  overflow_q, overflow_d;
    logic                  line_err_q, line_err_d;
    logic                  frame_err_q, frame_err_d;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;

    logic [CW-1:0]         beat_col, beat_row, beat_cap, beat_rows;
    logic                  beat_sof, in_active, line_end, row_in_win, col_in_win;
    logic                  capture, push, pop, full, drop;
    logic [EW-1:0]         rd_entry;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fs_q) begin
            state_d = S_ACTIVE;
        end else if (fe_q) begin
            state_d = S_IDLE;
        end
    end

    // A frame_start aligned with a beat makes that beat col 0 of row 0, so the
    // per-beat view of the counters is taken as already cleared.
    always_comb begin
        in_active  = fs_q || (state_q == S_ACTIVE);
        beat_col   = fs_q ? '0 : col_q;
        beat_row   = fs_q ? '0 : row_q;
        beat_cap   = fs_q ? '0 : cap_q;
        beat_rows  = fs_q ? '0 : rows_q;
        beat_sof   = fs_q || sof_q;
        line_end   = !valid_q && !fs_q && (gap_q == GAP_LAST);
        row_in_win = (beat_row >= V_LO) && (beat_row < V_HI);
        col_in_win = (beat_col >= H_LO) && (beat_col < H_HI);
        capture    = valid_q && in_active && row_in_win && col_in_win;

        pop  = O_raw_tvalid && O_raw_tready;
        full = (count_q == FIFO_FULL);
        push = capture && (!full || pop);
        drop = capture && full && !pop;

        gap_d = gap_q;
        if (valid_q || fs_q) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + CW'(1);
        end

        col_d = beat_col;
        if (line_end) begin
            col_d = '0;
        end else if (valid_q && (beat_col != CNT_MAX)) begin
            col_d = beat_col + CW'(1);
        end

        row_d = beat_row;
        if (line_end && (row_q != CNT_MAX)) begin
            row_d = row_q + CW'(1);
        end

        cap_d  = line_end ? '0 : beat_cap + CW'(capture);
        rows_d = beat_rows + CW'(capture && (beat_cap == '0));
        sof_d  = beat_sof && !capture;

        overflow_d  = (fs_q ? 1'b0 : overflow_q) || drop;
        line_err_d  = line_end && row_in_win && (cap_q != '0) && (cap_q < CAP_FULL);
        frame_err_d = fe_q && !fs_q && (state_q == S_ACTIVE) && (rows_d != ROWS_EXP);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            gap_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cap_q       <= '0;
            rows_q      <= '0;
            sof_q       <= 1'b0;
            overflow_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            data_q      <= I_raw_data;
            valid_q     <= I_raw_valid;
            fs_q        <= I_raw_frame_start;
            fe_q        <= I_raw_frame_end;
            gap_q       <= gap_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cap_q       <= cap_d;
            rows_q      <= rows_d;
            sof_q       <= sof_d;
            overflow_q  <= overflow_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge I_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {beat_sof, (beat_col == H_LAST), data_q};
        end
    end

    assign rd_entry     = mem[rd_ptr_q];
    assign O_raw_tvalid = (count_q != '0);
    assign O_raw_tdata  = O_raw_tvalid ? rd_entry[DATA_WIDTH-1:0] : '0;
    assign O_raw_tlast  = O_raw_tvalid && rd_entry[DATA_WIDTH];
    assign O_raw_tuser  = O_raw_tvalid && rd_entry[DATA_WIDTH+1];
    assign O_raw_tdest  = TDEST_WIDTH'(TDEST_VALUE);
    assign O_overflow   = overflow_q;
    assign O_line_err   = line_err_q;
    assign O_frame_err  = frame_err_q;

endmodule
